// File: rtl/sync_fifo_axis.sv
// Synchronous first-word-fall-through FIFO with AXI-Stream style handshakes.
// Each entry stores the payload together with its tlast flag. Occupancy and
// the threshold flags are registered so they can feed downstream
// sequencing logic without adding combinational depth.
module sync_fifo_axis #(
   parameter int ADDR_WIDTH    = 4,
   parameter int DATA_WIDTH    = 16,
   parameter int AFULL_THRESH  = (2 ** ADDR_WIDTH) - 2,
   parameter int AEMPTY_THRESH = 2
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic                  flush,
   input  logic                  s_tvalid,
   output logic                  s_tready,
   input  logic [DATA_WIDTH-1:0] s_tdata,
   input  logic                  s_tlast,
   output logic                  m_tvalid,
   input  logic                  m_tready,
   output logic [DATA_WIDTH-1:0] m_tdata,
   output logic                  m_tlast,
   output logic [ADDR_WIDTH:0]   level,
   output logic                  almost_full,
   output logic                  almost_empty
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam int PTR_W = ADDR_WIDTH + 1;

   // Storage is deliberately left without reset; stale entries are never
   // visible because the read port is masked whenever the FIFO is empty.
   logic [DATA_WIDTH:0] mem [DEPTH];

   logic [PTR_W-1:0]    wr_ptr;
   logic [PTR_W-1:0]    rd_ptr;
   logic [ADDR_WIDTH:0] level_nxt;
   logic [DATA_WIDTH:0] head;
   logic                full;
   logic                empty;
   logic                push;
   logic                pop;

   // Status derived from the registered pointers only, so ready/valid never
   // depend combinationally on the partner's handshake input.
   always_comb begin
      empty    = (wr_ptr == rd_ptr);
      full     = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                 (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);
      s_tready = !full;
      m_tvalid = !empty;
   end

   // Handshake qualification; flush overrides both sides for that cycle.
   always_comb begin
      push = s_tvalid && s_tready && !flush;
      pop  = m_tvalid && m_tready && !flush;
   end

   // Write port: payload and frame delimiter stored together at wr_ptr.
   always_ff @(posedge aclk) begin
      if (push) begin
         mem[wr_ptr[ADDR_WIDTH-1:0]] <= {s_tlast, s_tdata};
      end
   end

   // Pointer update; the extra MSB toggles on each wrap to separate full from empty.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
      end
   end

   // Next occupancy, shared by the level register and the threshold flags.
   always_comb begin
      level_nxt = level;
      if (flush) begin
         level_nxt = '0;
      end else if (push && !pop) begin
         level_nxt = level + PTR_W'(1);
      end else if (pop && !push) begin
         level_nxt = level - PTR_W'(1);
      end
   end

   // Level and flags registered together so they always agree in the same cycle.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         level        <= '0;
         almost_full  <= 1'b0;
         almost_empty <= 1'b1;
      end else begin
         level        <= level_nxt;
         almost_full  <= (int'(level_nxt) >= AFULL_THRESH);
         almost_empty <= (int'(level_nxt) <= AEMPTY_THRESH);
      end
   end

   // First-word-fall-through read of the head entry, zeroed when empty.
   always_comb begin
      head    = mem[rd_ptr[ADDR_WIDTH-1:0]];
      m_tdata = '0;
      m_tlast = 1'b0;
      if (m_tvalid) begin
         m_tdata = head[DATA_WIDTH-1:0];
         m_tlast = head[DATA_WIDTH];
      end
   end

endmodule

// File: tb/tb_sync_fifo_axis.sv
// Directed bench for sync_fifo_axis with a queue-based reference model.
module tb_sync_fifo_axis;

   localparam int AW    = 4;
   localparam int DW    = 16;
   localparam int DEPTH = 16;

   logic          aclk;
   logic          aresetn;
   logic          flush;
   logic          s_tvalid;
   logic          s_tready;
   logic [DW-1:0] s_tdata;
   logic          s_tlast;
   logic          m_tvalid;
   logic          m_tready;
   logic [DW-1:0] m_tdata;
   logic          m_tlast;
   logic [AW:0]   level;
   logic          almost_full;
   logic          almost_empty;

   int errors = 0;
   int checks = 0;

   logic [DW:0] q[$];

   sync_fifo_axis #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .aclk(aclk), .aresetn(aresetn), .flush(flush),
      .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tlast(s_tlast),
      .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast),
      .level(level), .almost_full(almost_full), .almost_empty(almost_empty)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a bounded queue updated from the handshake rules.
   always @(negedge aresetn) q.delete();

   always @(posedge aclk) begin
      if (!aresetn || flush) begin
         q.delete();
      end else begin
         automatic bit do_push = s_tvalid && (q.size() < DEPTH);
         automatic bit do_pop  = m_tready && (q.size() > 0);
         if (do_pop) void'(q.pop_front());
         if (do_push) q.push_back({s_tlast, s_tdata});
      end
   end

   // Every falling edge: all outputs against the model.
   always @(negedge aclk) begin
      automatic int n = q.size();
      chk("level", 32'(level), 32'(n));
      chk("s_tready", 32'(s_tready), 32'(n < DEPTH));
      chk("m_tvalid", 32'(m_tvalid), 32'(n > 0));
      chk("almost_full", 32'(almost_full), 32'(n >= DEPTH - 2));
      chk("almost_empty", 32'(almost_empty), 32'(n <= 2));
      chk("m_tdata", 32'(m_tdata), (n > 0) ? 32'(q[0][DW-1:0]) : 32'd0);
      chk("m_tlast", 32'(m_tlast), (n > 0) ? 32'(q[0][DW]) : 32'd0);
   end

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic push_n(input int n, input logic [DW-1:0] base);
      s_tvalid = 1'b1;
      m_tready = 1'b0;
      for (int i = 0; i < n; i++) begin
         s_tdata = base + DW'(i);
         tick();
      end
      s_tvalid = 1'b0;
   endtask

   initial begin
      aresetn  = 1'b0;
      flush    = 1'b0;
      s_tvalid = 1'b0;
      s_tdata  = '0;
      s_tlast  = 1'b0;
      m_tready = 1'b0;
      tick();
      tick();
      chk("rst_level", 32'(level), 32'd0);
      chk("rst_s_tready", 32'(s_tready), 32'd1);
      chk("rst_almost_empty", 32'(almost_empty), 32'd1);
      aresetn = 1'b1;
      tick();

      // Fill to full with m_tready low
      s_tvalid = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         s_tdata = DW'(i);
         tick();
         chk("fill_level", 32'(level), 32'(i));
         if (i == 13) chk("afull_at13", 32'(almost_full), 32'd0);
         if (i == 14) chk("afull_at14", 32'(almost_full), 32'd1);
      end
      chk("full_s_tready", 32'(s_tready), 32'd0);
      s_tdata = 16'hFFFF;
      tick();
      chk("full_no_write_level", 32'(level), 32'd16);
      chk("full_head", 32'(m_tdata), 32'h0001);

      // Drain in order
      s_tvalid = 1'b0;
      m_tready = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         chk("drain_data", 32'(m_tdata), 32'(i));
         tick();
      end
      chk("drain_m_tvalid", 32'(m_tvalid), 32'd0);
      chk("drain_m_tdata", 32'(m_tdata), 32'd0);
      chk("drain_level", 32'(level), 32'd0);

      // Frame delimiter travels with the third word only
      s_tvalid = 1'b1;
      m_tready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         s_tdata = 16'h0100 + DW'(i);
         s_tlast = (i == 2);
         tick();
      end
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      m_tready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk("tlast_data", 32'(m_tdata), 32'h0100 + 32'(i));
         chk("tlast_flag", 32'(m_tlast), 32'(i == 2));
         tick();
      end
      m_tready = 1'b0;

      // Level 5, streaming through several pointer wraps
      push_n(5, 16'h0200);
      s_tvalid = 1'b1;
      m_tready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         s_tdata = 16'h0205 + DW'(i);
         chk("stream_data", 32'(m_tdata), 32'h0200 + 32'(i));
         tick();
         chk("stream_level", 32'(level), 32'd5);
      end
      s_tvalid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("stream_tail", 32'(m_tdata), 32'h0228 + 32'(i));
         tick();
      end
      chk("stream_empty", 32'(m_tvalid), 32'd0);
      m_tready = 1'b0;

      // Flush wins over a simultaneous push and pop
      push_n(7, 16'h0300);
      chk("pre_flush_level", 32'(level), 32'd7);
      flush    = 1'b1;
      s_tvalid = 1'b1;
      s_tdata  = 16'hDEAD;
      m_tready = 1'b1;
      tick();
      flush    = 1'b0;
      s_tvalid = 1'b0;
      m_tready = 1'b0;
      chk("flush_level", 32'(level), 32'd0);
      chk("flush_m_tvalid", 32'(m_tvalid), 32'd0);
      chk("flush_almost_empty", 32'(almost_empty), 32'd1);
      tick();
      chk("flush_dropped", 32'(m_tvalid), 32'd0);

      // Asynchronous reset mid-cycle at level 9
      push_n(9, 16'h0400);
      chk("pre_rst_level", 32'(level), 32'd9);
      #2;
      aresetn = 1'b0;
      #1;
      chk("arst_level", 32'(level), 32'd0);
      chk("arst_m_tvalid", 32'(m_tvalid), 32'd0);
      chk("arst_m_tdata", 32'(m_tdata), 32'd0);
      chk("arst_s_tready", 32'(s_tready), 32'd1);
      chk("arst_almost_empty", 32'(almost_empty), 32'd1);
      chk("arst_almost_full", 32'(almost_full), 32'd0);
      tick();
      aresetn = 1'b1;
      tick();
      push_n(1, 16'hABCD);
      chk("post_rst_data", 32'(m_tdata), 32'h0000ABCD);
      chk("post_rst_level", 32'(level), 32'd1);
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
